// File: rtl/cic_interp.sv
// Second-order CIC interpolator (R = 2^LOG2R) for the DAC-side path.
//
// Low-rate signed 10-bit samples enter through a one-entry holding register with a
// valid/ready handshake. On every DAC tick (out_en) the integrators advance; on the
// first tick of each R-tick frame (phase 0) the held sample is consumed and pushed
// through the two combs, otherwise a zero is stuffed. The integrator output is
// divided by R (arithmetic shift) and clamped to 10 bits, which makes the output a
// linear interpolation between successive input samples with unity DC gain.
//
// Ports:
//   clk        clock
//   rst        asynchronous, active-low reset
//   in_data    signed input sample
//   in_valid   in_data is valid
//   in_ready   holding register is empty and can accept a sample
//   out_en     DAC tick; one output sample per tick
//   out_data   signed interpolated sample (registered)
//   out_valid  one-cycle pulse, out_data updated this cycle
//   underrun   one-cycle pulse, a sample was due but none was held
module cic_interp #(
    parameter int unsigned LOG2R = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       out_en,
    output logic [9:0] out_data,
    output logic       out_valid,
    output logic       underrun
);

    localparam int unsigned W = 10 + 2 * LOG2R;

    localparam logic signed [W-1:0] SatMax = W'(511);
    localparam logic signed [W-1:0] SatMin = W'(-512);

    logic signed [9:0]   hold_q, hold_d;
    logic                hold_valid_q, hold_valid_d;
    logic [LOG2R-1:0]    ph_q, ph_d;
    logic signed [W-1:0] x_dly_q, x_dly_d;
    logic signed [W-1:0] c1_dly_q, c1_dly_d;
    logic signed [W-1:0] i1_q, i1_d;
    logic signed [W-1:0] i2_q, i2_d;
    logic signed [9:0]   out_q, out_d;
    logic                out_valid_q, out_valid_d;
    logic                underrun_q, underrun_d;

    logic                accept;
    logic                consume;
    logic signed [W-1:0] x;
    logic signed [W-1:0] c1;
    logic signed [W-1:0] c2;
    logic signed [W-1:0] u;
    logic signed [W-1:0] i2_shift;

    assign in_ready  = !hold_valid_q;
    assign out_data  = out_q;
    assign out_valid = out_valid_q;
    assign underrun  = underrun_q;

    always_comb begin
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        ph_d         = ph_q;
        x_dly_d      = x_dly_q;
        c1_dly_d     = c1_dly_q;
        i1_d         = i1_q;
        i2_d         = i2_q;
        out_d        = out_q;
        out_valid_d  = out_en;
        underrun_d   = 1'b0;

        accept  = in_valid && !hold_valid_q;
        consume = out_en && (ph_q == '0);

        // An empty hold on a consume repeats the previous sample (flat output).
        x  = hold_valid_q ? {{(W-10){hold_q[9]}}, hold_q} : x_dly_q;
        c1 = x - x_dly_q;
        c2 = c1 - c1_dly_q;
        u  = consume ? c2 : '0;

        i2_shift = i2_q >>> LOG2R;

        // Accept and a hold-emptying consume are exclusive: accept needs the hold empty.
        if (accept) begin
            hold_d       = in_data;
            hold_valid_d = 1'b1;
        end

        if (consume) begin
            x_dly_d  = x;
            c1_dly_d = c1;
            if (hold_valid_q) begin
                hold_valid_d = 1'b0;
            end else begin
                underrun_d = 1'b1;
            end
        end

        if (out_en) begin
            ph_d = ph_q + 1'b1;
            i1_d = i1_q + u;
            i2_d = i2_q + i1_q;
            if (i2_shift > SatMax) begin
                out_d = 10'(SatMax);
            end else if (i2_shift < SatMin) begin
                out_d = 10'(SatMin);
            end else begin
                out_d = i2_shift[9:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            ph_q         <= '0;
            x_dly_q      <= '0;
            c1_dly_q     <= '0;
            i1_q         <= '0;
            i2_q         <= '0;
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            ph_q         <= ph_d;
            x_dly_q      <= x_dly_d;
            c1_dly_q     <= c1_dly_d;
            i1_q         <= i1_d;
            i2_q         <= i2_d;
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            underrun_q   <= underrun_d;
        end
    end

endmodule

// File: doc/cic_interp.md
Name: cic_interp

Overview:
Second-order CIC interpolator for the DAC-side path, the reconstruction counterpart of the ADC-side leaky-integrator smoothing filter.
- Accepts signed 10-bit samples at the low rate through a valid/ready handshake.
- Zero-stuffs them by R = 2^LOG2R and integrates at the DAC tick rate (out_en).
- Emits gain-normalised, saturated 10-bit samples, so the output is a linear interpolation between input samples.

Parameters:
LOG2R, 2, log2 of interpolation ratio R (R = 4 default); legal range 1..6
W (localparam), 10+2*LOG2R, internal comb/integrator width; two's-complement wrap arithmetic

Ports:
clk  input  1  clock
rst  input  1  asynchronous, active-low reset
in_data  input  10  signed input sample
in_valid  input  1  in_data valid
in_ready  output  1  block can accept a sample this cycle
out_en  input  1  DAC sample tick; one output sample per tick
out_data  output  10  signed interpolated sample
out_valid  output  1  one-cycle pulse, out_data updated this cycle
underrun  output  1  one-cycle pulse, sample needed but none held

Behaviour:
- Reset (async, rst=0) clears the following; reset mid-operation discards the held sample and all filter state immediately:
  - hold register and hold_valid
  - phase counter
  - x_d, c1_d
  - i1, i2
  - out_data=0, out_valid=0, underrun=0
  - in_ready=1 from the first cycle after reset release
- Input holding register, 1 entry:
  - in_ready = !hold_valid.
  - Accept when in_valid && in_ready: hold <= in_data, hold_valid <= 1.
  - No bypass. A sample accepted in a cycle is not visible to a consume in that same cycle.
- Phase counter ph, 0..R-1: advances only on out_en and wraps from R-1 to 0.
- Consume, on out_en && ph==0:
  - If hold_valid: x = hold and hold_valid <= 0. If an accept is also attempted, it is blocked because in_ready=0 that cycle.
  - Else: x = x_d (repeat previous sample) and underrun pulses for 1 cycle.
- Combs, updated only on consume, W-bit wrap:
  - c1 = x - x_d, c2 = c1 - c1_d
  - x_d <= x, c1_d <= c1
- Zero-stuff: u = c2 when consuming, else 0.
- Integrators, updated on every out_en, W-bit wrap:
  - i1 <= i1 + u
  - i2 <= i2 + i1 (old i1)
- Output, on every out_en:
  - out_data <= sat10(i2_old >>> LOG2R): arithmetic shift (floor), clamped to [-512, 511].
  - out_valid <= 1 the following cycle only, i.e. out_valid = registered out_en.
- Latency: a step consumed at tick k first moves out_data at tick k+2 and reaches the final value at tick k+R+1.
- DC gain after normalisation is exactly 1.
- out_en gaps: state holds. out_en may be asserted on consecutive cycles.
- Wrap arithmetic inside combs/integrators is required and must not be saturated; saturation applies only at the output.

Test Plan:
1. Reset then idle, with out_en held 0 → out_data=0, out_valid=0, underrun=0, in_ready=1; in_ready=1 persists when rst is asserted mid-stream with hold full.
2. LOG2R=2: preload 0, then feed 100 ahead of each consume, with out_en every cycle → out_data sequence over successive ticks after the step consume: 0, 0, 25, 50, 75, 100, 100…; out_valid pulses every cycle.
3. Constant -3 input, R=4 → steady out_data=-3 (no floor bias at exact multiples); constant 511 → steady 511; constant -512 → steady -512.
4. Handshake: in_valid held 1 with out_en every 3rd cycle →
   - in_ready drops the cycle after an accept.
   - in_ready rises the cycle after the ph==0 consume.
   - Exactly one sample is accepted per R ticks, with no loss or duplication (check by an incrementing data pattern).
5. Underrun: stop feeding after sample 200 → underrun pulses at each subsequent ph==0 tick; out_data settles at 200. Resume with 0 → out_data ramps 150, 100, 50, 0.
6. Alternating ±511 at R=2 → no wrap artefacts; out_data stays within [-512, 511] and the output matches a golden reference model sample-for-sample.
